// File: rtl/adc_dac_stream_ctrl.sv
// -----------------------------------------------------------------------------
// adc_dac_stream_ctrl
//
// Multi-channel ADC/DAC front-end controller. Drives NUM_DAC DAC lanes from a
// shared stimulus source, a per-lane constant or an idle mid-scale level, and
// captures NUM_CH ADC channels through an ADC_PIPE-deep register pipeline. The
// captured stream is gated by a settle window (counted in valid source cycles),
// a gap policy and sticky overrange flags, and leaves as a valid-qualified
// stream.
//
// Ports
//   clock          sample clock
//   reset          asynchronous, active-high reset
//   enable         run request; low forces IDLE on the next cycle
//   settle_cycles  valid source cycles discarded before output (latched on
//                  leaving IDLE)
//   dac_sel        per DAC lane: 0 = src_data, 1 = dac_const
//   dac_const      constant DAC code
//   src_data       stimulus sample from the lookup-table source
//   src_valid      src_data valid
//   adc_data       raw ADC buses, channel i at [i*ADC_W +: ADC_W]
//   adc_otr        raw ADC overrange bits
//   clear_otr      clears the sticky overrange flags
//   dac_data       registered DAC codes, lane k at [k*DAC_W +: DAC_W]
//   out_data       captured ADC samples (last pipeline stage)
//   out_valid      out_data valid
//   out_otr        sticky overrange flags
//   state          FSM state: 0 = IDLE, 1 = SETTLE, 2 = RUN
//   sample_cnt     number of out_valid cycles since the last IDLE exit
// -----------------------------------------------------------------------------
module adc_dac_stream_ctrl #(
    parameter int unsigned ADC_W          = 14,
    parameter int unsigned DAC_W          = 14,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned NUM_DAC        = 2,
    parameter int unsigned ADC_PIPE       = 1,
    parameter int unsigned IDLE_LEVEL     = 8192,
    parameter int unsigned RESTART_ON_GAP = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [15:0]               settle_cycles,
    input  logic [NUM_DAC-1:0]        dac_sel,
    input  logic [DAC_W-1:0]          dac_const,
    input  logic [DAC_W-1:0]          src_data,
    input  logic                      src_valid,
    input  logic [NUM_CH*ADC_W-1:0]   adc_data,
    input  logic [NUM_CH-1:0]         adc_otr,
    input  logic                      clear_otr,
    output logic [NUM_DAC*DAC_W-1:0]  dac_data,
    output logic [NUM_CH*ADC_W-1:0]   out_data,
    output logic                      out_valid,
    output logic [NUM_CH-1:0]         out_otr,
    output logic [1:0]                state,
    output logic [31:0]               sample_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic [DAC_W-1:0] IDLE_CODE = DAC_W'(IDLE_LEVEL);

    state_t                     state_q, state_d;
    logic [15:0]                settle_lat_q, settle_lat_d;
    logic [15:0]                settle_cnt_q, settle_cnt_d;

    logic [NUM_DAC*DAC_W-1:0]   dac_q, dac_d;
    logic                       out_valid_q, out_valid_d;
    logic [NUM_CH-1:0]          out_otr_q, out_otr_d;
    logic [31:0]                sample_cnt_q, sample_cnt_d;

    logic [NUM_CH*ADC_W-1:0]    adc_pipe_q [ADC_PIPE];
    logic [NUM_CH-1:0]          otr_pipe_q [ADC_PIPE];

    logic                       settle_done;
    logic                       run_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            settle_lat_q <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_lat_q <= settle_lat_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    // A latched window of 0 is treated as already satisfied so that a
    // gap-restart with a zero window cannot leave the counter running.
    assign settle_done = (settle_lat_q == 16'd0) ||
                         ((settle_cnt_q + 16'd1) == settle_lat_q);

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        settle_lat_d = settle_lat_q;
        settle_cnt_d = settle_cnt_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    settle_lat_d = settle_cycles;
                    settle_cnt_d = '0;
                    state_d      = (settle_cycles == 16'd0) ? ST_RUN : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (src_valid) begin
                        settle_cnt_d = settle_cnt_q + 16'd1;
                        if (settle_done) begin
                            state_d = ST_RUN;
                        end
                    end else if (RESTART_ON_GAP != 0) begin
                        settle_cnt_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!src_valid && (RESTART_ON_GAP != 0)) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    assign run_valid = (state_q == ST_RUN) && src_valid;

    always_comb begin
        out_valid_d = run_valid && enable;

        // The count includes the cycle being flagged, so it reads 1 on the
        // very first out_valid cycle.
        sample_cnt_d = sample_cnt_q;
        if ((state_q == ST_IDLE) && enable) begin
            sample_cnt_d = '0;
        end else if (out_valid_d) begin
            sample_cnt_d = sample_cnt_q + 32'd1;
        end

        dac_d = '0;
        for (int unsigned k = 0; k < NUM_DAC; k++) begin
            if ((state_q == ST_IDLE) || !src_valid) begin
                dac_d[k*DAC_W +: DAC_W] = IDLE_CODE;
            end else if (dac_sel[k]) begin
                dac_d[k*DAC_W +: DAC_W] = dac_const;
            end else begin
                dac_d[k*DAC_W +: DAC_W] = src_data;
            end
        end

        // Set takes precedence over clear on the same cycle.
        out_otr_d = (out_otr_q & ~{NUM_CH{clear_otr}}) |
                    (run_valid ? otr_pipe_q[ADC_PIPE-1] : '0);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dac_q        <= {NUM_DAC{IDLE_CODE}};
            out_valid_q  <= 1'b0;
            out_otr_q    <= '0;
            sample_cnt_q <= '0;
        end else begin
            dac_q        <= dac_d;
            out_valid_q  <= out_valid_d;
            out_otr_q    <= out_otr_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Free-running ADC capture pipeline, overrange bits travel alongside
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ADC_PIPE; i++) begin
                adc_pipe_q[i] <= '0;
                otr_pipe_q[i] <= '0;
            end
        end else begin
            adc_pipe_q[0] <= adc_data;
            otr_pipe_q[0] <= adc_otr;
            for (int unsigned i = 1; i < ADC_PIPE; i++) begin
                adc_pipe_q[i] <= adc_pipe_q[i-1];
                otr_pipe_q[i] <= otr_pipe_q[i-1];
            end
        end
    end

    assign dac_data   = dac_q;
    assign out_data   = adc_pipe_q[ADC_PIPE-1];
    assign out_valid  = out_valid_q;
    assign out_otr    = out_otr_q;
    assign state      = state_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_adc_dac_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_dac_stream_ctrl
//
// Directed bench for adc_dac_stream_ctrl. Two instances share all inputs: u0
// pauses on source gaps, u1 restarts the settle window on a gap. DAC codes and
// captured ADC words are predicted when stimulus is driven (scoreboard queues)
// and compared after the clock edge that produces them.
// -----------------------------------------------------------------------------
module tb_adc_dac_stream_ctrl;

    localparam int unsigned ADC_W   = 14;
    localparam int unsigned DAC_W   = 14;
    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned NUM_DAC = 2;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      enable;
    logic [15:0]               settle_cycles;
    logic [NUM_DAC-1:0]        dac_sel;
    logic [DAC_W-1:0]          dac_const;
    logic [DAC_W-1:0]          src_data;
    logic                      src_valid;
    logic [NUM_CH*ADC_W-1:0]   adc_data;
    logic [NUM_CH-1:0]         adc_otr;
    logic                      clear_otr;

    logic [NUM_DAC*DAC_W-1:0]  dac_data0, dac_data1;
    logic [NUM_CH*ADC_W-1:0]   out_data0, out_data1;
    logic                      out_valid0, out_valid1;
    logic [NUM_CH-1:0]         out_otr0, out_otr1;
    logic [1:0]                state0, state1;
    logic [31:0]               sample_cnt0, sample_cnt1;

    int checks   = 0;
    int failures = 0;
    int exp_cnt0 = 0;

    logic [NUM_DAC*DAC_W-1:0]  dac_sb [$];
    logic [NUM_CH*ADC_W-1:0]   adc_sb [$];

    always #5 clock = ~clock;

    adc_dac_stream_ctrl #(
        .ADC_W(ADC_W), .DAC_W(DAC_W), .NUM_CH(NUM_CH), .NUM_DAC(NUM_DAC),
        .ADC_PIPE(1), .IDLE_LEVEL(8192), .RESTART_ON_GAP(0)
    ) u0 (
        .clock(clock), .reset(reset), .enable(enable),
        .settle_cycles(settle_cycles), .dac_sel(dac_sel), .dac_const(dac_const),
        .src_data(src_data), .src_valid(src_valid), .adc_data(adc_data),
        .adc_otr(adc_otr), .clear_otr(clear_otr), .dac_data(dac_data0),
        .out_data(out_data0), .out_valid(out_valid0), .out_otr(out_otr0),
        .state(state0), .sample_cnt(sample_cnt0)
    );

    adc_dac_stream_ctrl #(
        .ADC_W(ADC_W), .DAC_W(DAC_W), .NUM_CH(NUM_CH), .NUM_DAC(NUM_DAC),
        .ADC_PIPE(1), .IDLE_LEVEL(8192), .RESTART_ON_GAP(1)
    ) u1 (
        .clock(clock), .reset(reset), .enable(enable),
        .settle_cycles(settle_cycles), .dac_sel(dac_sel), .dac_const(dac_const),
        .src_data(src_data), .src_valid(src_valid), .adc_data(adc_data),
        .adc_otr(adc_otr), .clear_otr(clear_otr), .dac_data(dac_data1),
        .out_data(out_data1), .out_valid(out_valid1), .out_otr(out_otr1),
        .state(state1), .sample_cnt(sample_cnt1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected DAC word: idle level on every lane, else per-lane source select.
    function automatic logic [NUM_DAC*DAC_W-1:0] dac_model(
        input bit idle, input logic [NUM_DAC-1:0] sel,
        input logic [DAC_W-1:0] cst, input logic [DAC_W-1:0] src);
        logic [NUM_DAC*DAC_W-1:0] r;
        for (int k = 0; k < NUM_DAC; k++) begin
            r[k*DAC_W +: DAC_W] = idle ? 14'd8192 : (sel[k] ? cst : src);
        end
        return r;
    endfunction

    // One clock: drive a fresh ADC word, predict DAC/ADC results, compare after
    // the edge. st_idle is the state the bench expects the DUT to be in at the edge.
    task automatic tick(input bit st_idle);
        logic [NUM_CH*ADC_W-1:0] a;
        a = 28'($urandom);
        adc_data = a;
        adc_sb.push_back(a);
        dac_sb.push_back(dac_model(st_idle || !src_valid, dac_sel, dac_const, src_data));
        @(posedge clock);
        #1;
        check("out_data", out_data0, adc_sb.pop_front());
        check("dac_data", dac_data0, dac_sb.pop_front());
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        settle_cycles = 16'd11;
        dac_sel       = 2'b00;
        dac_const     = '0;
        src_data      = 14'd100;
        src_valid     = 1'b1;
        adc_data      = '0;
        adc_otr       = '0;
        clear_otr     = 1'b0;

        // Reset values while reset is held
        #12;
        check("rst_state", state0, 2'd0);
        check("rst_dac", dac_data0, dac_model(1'b1, 2'b00, 14'd0, 14'd0));
        check("rst_valid", out_valid0, 1'b0);
        check("rst_cnt", sample_cnt0, 32'd0);
        check("rst_otr", out_otr0, 2'b00);
        check("rst_out_data", out_data0, 28'd0);
        #1 reset = 1'b0;

        // Idle with source active: DAC stays at idle level
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            check("idle_state", state0, 2'd0);
            check("idle_valid", out_valid0, 1'b0);
        end

        // Start with an 11-cycle settle window, continuous source
        enable = 1'b1;
        tick(1'b1);
        check("start_state", state0, 2'd1);
        check("start_valid", out_valid0, 1'b0);
        for (int n = 1; n <= 14; n++) begin
            src_data = 14'(14'h200 + n);
            tick(1'b0);
            check("settle_state", state0, (n < 11) ? 2'd1 : 2'd2);
            check("settle_state_u1", state1, (n < 11) ? 2'd1 : 2'd2);
            check("first_valid", out_valid0, (n >= 12) ? 1'b1 : 1'b0);
            check("first_cnt", sample_cnt0, (n >= 12) ? 32'(n - 11) : 32'd0);
        end
        exp_cnt0 = 3;

        // Three-cycle source gap in RUN
        src_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tick(1'b0);
            check("gap_state_u0", state0, 2'd2);
            check("gap_valid_u0", out_valid0, 1'b0);
            check("gap_cnt_u0", sample_cnt0, 32'(exp_cnt0));
            check("gap_state_u1", state1, 2'd1);
            check("gap_valid_u1", out_valid1, 1'b0);
        end
        src_valid = 1'b1;
        for (int r = 1; r <= 12; r++) begin
            src_data = 14'(14'h300 + r);
            tick(1'b0);
            exp_cnt0++;
            check("resume_valid_u0", out_valid0, 1'b1);
            check("resume_cnt_u0", sample_cnt0, 32'(exp_cnt0));
            check("restart_state_u1", state1, (r < 11) ? 2'd1 : 2'd2);
            check("restart_valid_u1", out_valid1, (r == 12) ? 1'b1 : 1'b0);
            check("restart_cnt_u1", sample_cnt1, (r == 12) ? 32'd4 : 32'd3);
        end

        // Per-lane DAC source select
        dac_sel   = 2'b10;
        dac_const = 14'h1234;
        src_data  = 14'h0100;
        tick(1'b0);
        exp_cnt0++;
        check("sel10_lane1", dac_data0[27:14], 14'h1234);
        check("sel10_lane0", dac_data0[13:0], 14'h0100);
        dac_sel = 2'b01;
        tick(1'b0);
        exp_cnt0++;
        check("sel01_lane1", dac_data0[27:14], 14'h0100);
        check("sel01_lane0", dac_data0[13:0], 14'h1234);
        dac_sel = 2'b00;

        // Sticky overrange: set, hold, set-beats-clear, clear
        adc_otr = 2'b10;
        tick(1'b0);
        exp_cnt0++;
        check("otr_pipe_delay", out_otr0, 2'b00);
        adc_otr = 2'b00;
        tick(1'b0);
        exp_cnt0++;
        check("otr_set", out_otr0, 2'b10);
        tick(1'b0);
        exp_cnt0++;
        check("otr_hold", out_otr0, 2'b10);
        adc_otr = 2'b10;
        tick(1'b0);
        exp_cnt0++;
        adc_otr   = 2'b00;
        clear_otr = 1'b1;
        tick(1'b0);
        exp_cnt0++;
        check("otr_set_wins", out_otr0, 2'b10);
        tick(1'b0);
        exp_cnt0++;
        check("otr_clear", out_otr0, 2'b00);
        clear_otr = 1'b0;

        // Run up to 500 samples, then reset asynchronously mid-RUN
        adc_otr = 2'b01;
        tick(1'b0);
        exp_cnt0++;
        adc_otr = 2'b00;
        tick(1'b0);
        exp_cnt0++;
        check("otr_lane0", out_otr0, 2'b01);
        while (exp_cnt0 < 500) begin
            src_data = 14'($urandom);
            tick(1'b0);
            exp_cnt0++;
        end
        check("cnt_500", sample_cnt0, 32'd500);
        check("valid_before_rst", out_valid0, 1'b1);
        #2 reset = 1'b1;
        enable = 1'b0;
        #1;
        check("async_state", state0, 2'd0);
        check("async_dac", dac_data0, dac_model(1'b1, 2'b00, 14'd0, 14'd0));
        check("async_valid", out_valid0, 1'b0);
        check("async_cnt", sample_cnt0, 32'd0);
        check("async_otr", out_otr0, 2'b00);
        check("async_out_data", out_data0, 28'd0);
        @(posedge clock);
        #2 reset = 1'b0;

        // Enable dropped mid-SETTLE
        enable = 1'b1;
        tick(1'b1);
        check("re_start_state", state0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            src_data = 14'(14'h0400 + i);
            tick(1'b0);
            check("re_settle_state", state0, 2'd1);
        end
        enable = 1'b0;
        tick(1'b0);
        check("drop_state", state0, 2'd0);
        check("drop_valid", out_valid0, 1'b0);
        tick(1'b1);
        check("drop_dac_idle", dac_data0, dac_model(1'b1, 2'b00, 14'd0, 14'd0));
        check("drop_state_hold", state0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_dac_stream_ctrl.md
Name: adc_dac_stream_ctrl

Overview:
- Parametrised, multi-channel successor of the single-pair ADC/DAC front-end driver.
- Drives NUM_DAC DAC channels from a shared stimulus source, a per-channel constant, or an idle level.
- Captures NUM_CH ADC channels through a configurable register pipeline.
- Gates the ADC stream with a run-time settle window, a gap policy and sticky overrange flags, and emits a valid-qualified stream to the processing chain.

Parameters:
- ADC_W, 14, ADC sample width per channel.
- DAC_W, 14, DAC code width per channel.
- NUM_CH, 2, number of ADC channels.
- NUM_DAC, 2, number of DAC channels.
- ADC_PIPE, 1, ADC capture register stages, minimum 1.
- IDLE_LEVEL, 8192, DAC code driven when inactive (mid-scale, avoids the start-up slew jump).
- RESTART_ON_GAP, 0, 0 = source gaps pause the stream; 1 = a source gap restarts the settle window.

Ports:
- clock  in  1  sample clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request.
- settle_cycles  in  16  number of valid source cycles discarded before output; latched on leaving IDLE.
- dac_sel  in  NUM_DAC  per channel: 0 = src_data, 1 = dac_const.
- dac_const  in  DAC_W  constant DAC code.
- src_data  in  DAC_W  stimulus sample from the lookup-table source.
- src_valid  in  1  src_data valid.
- adc_data  in  NUM_CH*ADC_W  raw ADC buses; channel i at bits [i*ADC_W +: ADC_W].
- adc_otr  in  NUM_CH  raw ADC overrange bits.
- clear_otr  in  1  clears the sticky overrange flags.
- dac_data  out  NUM_DAC*DAC_W  registered DAC codes, same packing as adc_data.
- out_data  out  NUM_CH*ADC_W  captured ADC samples.
- out_valid  out  1  out_data valid.
- out_otr  out  NUM_CH  sticky overrange flags.
- state  out  2  FSM state: 0 = IDLE, 1 = SETTLE, 2 = RUN.
- sample_cnt  out  32  count of out_valid cycles.

Behaviour:
- Reset (asynchronous, any time, including mid-RUN):
  - state = IDLE, every dac_data lane = IDLE_LEVEL, ADC pipeline = 0.
  - out_data = 0, out_valid = 0, out_otr = 0, sample_cnt = 0, settle counter = 0.
- FSM:
  - IDLE: on enable=1, latch settle_cycles, clear the settle counter and clear sample_cnt. Next state is RUN if the latched value is 0, otherwise SETTLE.
  - SETTLE: the counter increments on each src_valid=1 cycle. On the valid cycle where counter+1 == latched value, go to RUN next.
  - RUN: hold.
  - enable=0 in any state: IDLE next cycle. This takes priority over every other transition.
- Gap policy:
  - RESTART_ON_GAP=0: src_valid=0 in SETTLE or RUN holds the state and the counter.
  - RESTART_ON_GAP=1: src_valid=0 in SETTLE or RUN forces SETTLE next with counter 0. A gap never clears sample_cnt.
- DAC, 1-cycle latency, per lane k:
  - If state==IDLE or src_valid==0: dac_data lane <= IDLE_LEVEL.
  - Else: dac_data lane <= dac_const when dac_sel[k]=1, otherwise src_data.
- ADC capture:
  - adc_data passes through ADC_PIPE free-running registers; out_data is the last stage.
  - adc_otr is registered alongside each stage.
- out_valid:
  - Registered: out_valid <= (state==RUN) && src_valid && enable.
  - The first out_valid appears exactly settle_cycles+1 valid source cycles after enable rises (no gaps, settle_cycles ≥ 1).
- sample_cnt: increments on each cycle with out_valid=1, wraps modulo 2^32.
- out_otr[i]:
  - Set on a cycle with (state==RUN) && src_valid && delayed otr[i].
  - Cleared by clear_otr. If set and clear occur in the same cycle, set wins.
- settle_cycles and RESTART_ON_GAP are not re-sampled outside the IDLE exit; mid-run changes to settle_cycles are ignored.
- Widths: no arithmetic on data paths. The settle counter is 16 bits and cannot overflow, because it stops at the latched value.

Test Plan:
- Reset released with enable=0, src_valid=1, src_data=100 → dac_data lanes stay 8192, out_valid=0, state=0.
- enable=1, settle_cycles=11, continuous src_valid, dac_sel=00 → dac_data follows src_data after 1 cycle. State goes 1 then 2, and the first out_valid occurs on the 12th valid source cycle after enable. sample_cnt=1 on that cycle.
- RESTART_ON_GAP=0 with a 3-cycle src_valid gap during RUN → out_valid low for 3 cycles, state stays 2, dac_data=8192 during the gap. RESTART_ON_GAP=1 with the same gap → state returns to 1 and out_valid resumes after another 11 valid cycles.
- dac_sel=10, dac_const=0x1234, src_data=0x0100 → lane1=0x1234, lane0=0x0100.
- adc_otr[1] pulsed for 1 cycle in RUN → out_otr=10 and held. clear_otr together with a new otr[1] pulse → out_otr stays 10. clear_otr alone → out_otr=00.
- Reset asserted mid-RUN with sample_cnt=500 → all outputs return to reset values immediately, without waiting for a clock edge. enable dropped mid-SETTLE → IDLE next cycle and DAC lanes at 8192.
